mips_mc_ctrl: RTL and testbench



---
 rtl/mips_mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences datapath enables and selects
// one instruction at a time, stalling on memory via mem_ready.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_cond,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_ITEXEC = 4'd8,
        S_ITWB   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t cur;
    state_t nxt;

    always_ff @(posedge clk) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt        = S_FETCH;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_cond    = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                nxt       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:    nxt = S_MEMADR;
                    OP_R:            nxt = S_RTEXEC;
                    OP_ADDI, OP_ORI: nxt = S_ITEXEC;
                    OP_BEQ:          nxt = S_BRANCH;
                    OP_J:            nxt = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                nxt     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
                nxt     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTEXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_RTWB;
            end
            S_RTWB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            S_ITEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ORI) ? 2'b11 : 2'b00;
                nxt       = S_ITWB;
            end
            S_ITWB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_cond   = 1'b1;
                pc_src    = 2'b01;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 2'b10;
                retire = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
        // Reset aborts any in-flight access with every strobe low.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_cond    = 1'b0;
            pc_src     = 2'b00;
            reg_we     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            retire     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed instruction table, reset corners,
// and random instruction streams against a per-instruction cycle plan.
module tb_mips_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we, pc_cond;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       retire, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mips_mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .pc_cond(pc_cond), .pc_src(pc_src),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .retire(retire), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_we, pc_we, pc_cond;
        logic [1:0] pc_src;
        logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       retire, illegal;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        int wf, wm, cyc, ret, ill, rwe;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;

    obs_t       exp_q[$];
    logic       mr_q[$];
    logic [5:0] op_q[$];

    function automatic obs_t cur_obs();
        obs_t o;
        o = {mem_req, mem_we, iord, ir_we, pc_we, pc_cond, pc_src,
             reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             retire, illegal, state};
        return o;
    endfunction

    // Fixed per-state outputs, before mem_ready/opcode-dependent bits.
    function automatic obs_t base(input int s);
        obs_t o;
        o = '0;
        o.state = 4'(s);
        case (s)
            0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_req = 1; o.iord = 1; end
            4:  begin o.reg_we = 1; o.mem_to_reg = 1; o.retire = 1; end
            5:  begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_we = 1; o.reg_dst = 1; o.retire = 1; end
            8:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            9:  begin o.reg_we = 1; o.retire = 1; end
            10: begin
                o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_cond = 1;
                o.pc_src = 2'b01; o.retire = 1;
            end
            11: begin o.pc_we = 1; o.pc_src = 2'b10; o.retire = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check_obs(input string nm, input obs_t e);
        obs_t a;
        a = cur_obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: got %h required %h", nm, $time, a, e);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, a, e);
        end
    endtask

    task automatic push(input obs_t o, input logic mr, input logic [5:0] op);
        exp_q.push_back(o);
        mr_q.push_back(mr);
        op_q.push_back(op);
    endtask

    // Cycle plan for one instruction with wf fetch waits and wm data waits.
    task automatic gen(input logic [5:0] op, input int wf, input int wm);
        obs_t o;
        for (int i = 0; i < wf; i++) push(base(0), 1'b0, 6'($urandom));
        o = base(0); o.ir_we = 1; o.pc_we = 1;
        push(o, 1'b1, 6'($urandom));
        o = base(1);
        if (!(op inside {LW, SW, RT, ADDI, ORI, BEQ, JMP})) begin
            o.illegal = 1;
            push(o, 1'($urandom), op);
            return;
        end
        push(o, 1'($urandom), op);
        case (op)
            LW: begin
                push(base(2), 1'($urandom), op);
                for (int i = 0; i < wm; i++) push(base(3), 1'b0, op);
                push(base(3), 1'b1, op);
                push(base(4), 1'($urandom), op);
            end
            SW: begin
                push(base(2), 1'($urandom), op);
                for (int i = 0; i < wm; i++) push(base(5), 1'b0, op);
                o = base(5); o.retire = 1;
                push(o, 1'b1, op);
            end
            RT: begin
                push(base(6), 1'($urandom), op);
                push(base(7), 1'($urandom), op);
            end
            ADDI, ORI: begin
                o = base(8);
                if (op == ORI) o.alu_op = 2'b11;
                push(o, 1'($urandom), op);
                push(base(9), 1'($urandom), op);
            end
            BEQ: push(base(10), 1'($urandom), op);
            default: push(base(11), 1'($urandom), op);
        endcase
    endtask

    task automatic run_dir(input logic [5:0] op, input int wf, input int wm,
                           output int cyc, output int ret,
                           output int ill, output int rwe);
        int fc, mc;
        bit left, done;
        cyc = 0; ret = 0; ill = 0; rwe = 0;
        fc = 0; mc = 0; left = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            opcode = op;
            if (state == 4'd0) begin
                mem_ready = (fc >= wf); fc++;
            end else if (state == 4'd3 || state == 4'd5) begin
                mem_ready = (mc >= wm); mc++;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            ret += int'(retire);
            ill += int'(illegal);
            rwe += int'(reg_we);
            if (state != 4'd0) left = 1;
            @(posedge clk); #1;
            if (left && state == 4'd0) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL dir_timeout op=%b: no return to FETCH", op);
        end
    endtask

    vec_t tbl[10];
    logic [5:0] legal[7];

    initial begin
        obs_t e;
        int cyc, ret, ill, rwe;
        logic [5:0] op;

        tbl[0] = '{LW,   0, 0, 5, 1, 0, 1};
        tbl[1] = '{SW,   0, 2, 6, 1, 0, 0};
        tbl[2] = '{RT,   0, 0, 4, 1, 0, 1};
        tbl[3] = '{ADDI, 1, 0, 5, 1, 0, 1};
        tbl[4] = '{ORI,  0, 0, 4, 1, 0, 1};
        tbl[5] = '{BEQ,  0, 0, 3, 1, 0, 0};
        tbl[6] = '{JMP,  2, 0, 5, 1, 0, 0};
        tbl[7] = '{6'b111111, 0, 0, 2, 0, 1, 0};
        tbl[8] = '{LW,   1, 3, 9, 1, 0, 1};
        tbl[9] = '{SW,   0, 0, 4, 1, 0, 0};
        legal = '{LW, SW, RT, ADDI, ORI, BEQ, JMP};

        rst = 1'b1; mem_ready = 1'b1; opcode = 6'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs("reset_hold", '0);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check_obs("post_reset_fetch", base(0));
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run_dir(tbl[i].op, tbl[i].wf, tbl[i].wm, cyc, ret, ill, rwe);
            check_int($sformatf("dir%0d_cycles", i), cyc, tbl[i].cyc);
            check_int($sformatf("dir%0d_retire", i), ret, tbl[i].ret);
            check_int($sformatf("dir%0d_illegal", i), ill, tbl[i].ill);
            check_int($sformatf("dir%0d_reg_we", i), rwe, tbl[i].rwe);
        end

        opcode = LW; mem_ready = 1'b1;
        @(negedge clk);
        e = base(0); e.ir_we = 1; e.pc_we = 1;
        check_obs("abort_fetch", e);
        @(posedge clk); #1;
        @(negedge clk); check_obs("abort_decode", base(1));
        @(posedge clk); #1;
        @(negedge clk); check_obs("abort_memadr", base(2));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk); check_obs("abort_memrd_wait", base(3));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        e = '0; e.state = 4'd3;
        check_obs("abort_rst_cycle", e);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); check_obs("abort_refetch", base(0));
        @(posedge clk); #1;
        run_dir(RT, 0, 0, cyc, ret, ill, rwe);
        check_int("abort_next_cycles", cyc, 4);
        check_int("abort_next_retire", ret, 1);

        for (int n = 0; n < 150; n++) begin
            int idx;
            idx = int'($urandom_range(0, 7));
            if (idx < 7) begin
                op = legal[idx];
            end else begin
                op = 6'($urandom);
                if (op inside {LW, SW, RT, ADDI, ORI, BEQ, JMP})
                    op = 6'b111111;
            end
            gen(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mem_ready = mr_q.pop_front();
                opcode = op_q.pop_front();
                @(negedge clk);
                check_obs($sformatf("rand%0d_op%b", n, op), e);
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
